pe_array_sequencer: RTL and testbench
=====================================

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

Interface
REQ-001 SHALL use `N_PE, `ADDR_FIFO from header.vh; PE (r,c) maps to flat bit r*`N_PE+c.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  command strobe; accepted only in IDLE.
REQ-005 cfg_k  in  4  kernel size, legal 1..`N_PE.
REQ-006 cfg_row_length  in  `ADDR_FIFO  pixels per input row, legal >=1.
REQ-007 cfg_num_rows  in  `ADDR_FIFO  input rows, legal >=cfg_k.
REQ-008 cfg_channels  in  8  input-channel passes, 0 treated as 1.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse at command completion.
REQ-011 err  out  1  one-cycle pulse on rejected command.
REQ-012 shifting_line, shifting_filter, mac_enable  out  `N_PE*`N_PE each  per-PE controls.
REQ-013 nl_enable, feedback_enable, adder_enable  out  `N_PE each  per-column controls.
REQ-014 line_buffer_reset  out  1; row_length  out  `ADDR_FIFO  (latched cfg_row_length).

Function
REQ-015 States: IDLE, LB_RST, LOAD_FILTER, FILL, COMPUTE, DRAIN, DONE.
REQ-016 IDLE+start with legal config SHALL latch all cfg_* and go to LB_RST next cycle.
REQ-017 Illegal config (k=0, k>`N_PE, row_length=0, num_rows<k) SHALL pulse err next cycle and remain IDLE.
REQ-018 Mask M(r,c)=1 iff r<k and c<k; column mask C(c)=1 iff c<k.
REQ-019 LB_RST: 1 cycle, line_buffer_reset=1.
REQ-020 LOAD_FILTER: exactly k cycles, shifting_filter=M.
REQ-021 FILL: exactly (k-1)*row_length cycles, shifting_line=M; skipped when k=1.
REQ-022 COMPUTE: (num_rows-k+1)*row_length cycles, shifting_line=M and mac_enable=M.
REQ-023 DRAIN: 2 cycles; cycle 1 adder_enable=C, cycle 2 nl_enable=C.
REQ-024 DONE: 1 cycle; if passes remain, go to LB_RST for next pass, else pulse done and go IDLE.
REQ-025 Outputs not named for a state SHALL be 0 in that state; all outputs registered.
REQ-026 start while busy SHALL be ignored, no err.
REQ-027 Cycle counters SHALL be wide enough for row_length*num_rows with no wrap.

Reset
REQ-028 rst SHALL force IDLE and all outputs, counters and latched config to 0 in the next cycle, including mid-operation; no done pulse.
REQ-029 rst has priority over start in the same cycle.

Configuration
REQ-030 PE_SEQ_FEEDBACK_EN defined: multi-pass per cfg_channels; feedback_enable=C throughout COMPUTE and DRAIN of passes 2..N; done only after last pass.
REQ-031 PE_SEQ_FEEDBACK_EN undefined: feedback_enable tied 0, cfg_channels ignored, single pass.

Structure
REQ-032 Package pe_seq_pkg SHALL hold the state enum, counter-width localparam and k/row-length limits.
REQ-033 Sub-module pe_seq_mask_gen SHALL derive M and C from k combinationally; FSM and counters stay in top.

Verification
REQ-034 k=3,row_length=4,num_rows=5,channels=1 -> LB_RST 1, LOAD_FILTER 3, FILL 8, COMPUTE 12, DRAIN 2 cycles; done 27 cycles after start accepted.
REQ-035 k=1,row_length=2,num_rows=2 -> FILL skipped; mac_enable only bit 0 for 4 cycles.
REQ-036 k=`N_PE+1 or num_rows=k-1 -> err pulse 1 cycle, busy stays 0, no control outputs.
REQ-037 rst asserted mid-COMPUTE -> next cycle all outputs 0, IDLE; new start runs full sequence.
REQ-038 PE_SEQ_FEEDBACK_EN, channels=2 -> feedback_enable=0 pass 1, =C during pass 2 COMPUTE/DRAIN; single done.
REQ-039 start held high through a command -> exactly one command executed, no err.

Source files
------------

// File: rtl/pe_array_sequencer_pkg.sv
// Shared types, widths and limits for the PE-array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).

// Array size and address width normally come from the project header;
// these defaults apply only when it has not defined them already.
`ifndef N_PE
`define N_PE 4
`endif
`ifndef ADDR_FIFO
`define ADDR_FIFO 8
`endif

package pe_seq_pkg;

    localparam int N_PE    = `N_PE;
    localparam int ADDR_W  = `ADDR_FIFO;
    localparam int K_W     = 4;
    localparam int CHAN_W  = 8;

    // Large enough for row_length * num_rows (plus one spare bit) so no
    // phase length can wrap the cycle counter.
    localparam int CNT_W   = 2 * ADDR_W + 1;

    localparam int K_MIN       = 1;
    localparam int K_MAX       = N_PE;
    localparam int ROW_LEN_MIN = 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LB_RST      = 3'd1,
        S_LOAD_FILTER = 3'd2,
        S_FILL        = 3'd3,
        S_COMPUTE     = 3'd4,
        S_DRAIN       = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    // A command is runnable only if the kernel fits the array, rows are
    // non-empty and there are at least k input rows.
    function automatic logic cfg_legal(
        input logic [K_W-1:0]    k,
        input logic [ADDR_W-1:0] row_len,
        input logic [ADDR_W-1:0] num_rows
    );
        return (int'(k) >= K_MIN) && (int'(k) <= K_MAX) &&
               (int'(row_len) >= ROW_LEN_MIN) &&
               (int'(num_rows) >= int'(k));
    endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Command/config inputs and per-PE control outputs of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is a strobe, busy tells the master when it is honoured.

interface pe_array_sequencer_if;
    import pe_seq_pkg::*;

    logic                     start;
    logic [K_W-1:0]           cfg_k;
    logic [ADDR_W-1:0]        cfg_row_length;
    logic [ADDR_W-1:0]        cfg_num_rows;
    logic [CHAN_W-1:0]        cfg_channels;

    logic                     busy;
    logic                     done;
    logic                     err;
    logic [N_PE*N_PE-1:0]     shifting_line;
    logic [N_PE*N_PE-1:0]     shifting_filter;
    logic [N_PE*N_PE-1:0]     mac_enable;
    logic [N_PE-1:0]          nl_enable;
    logic [N_PE-1:0]          feedback_enable;
    logic [N_PE-1:0]          adder_enable;
    logic                     line_buffer_reset;
    logic [ADDR_W-1:0]        row_length;

    modport master (
        output start, cfg_k, cfg_row_length, cfg_num_rows, cfg_channels,
        input  busy, done, err, shifting_line, shifting_filter, mac_enable,
               nl_enable, feedback_enable, adder_enable, line_buffer_reset,
               row_length
    );

    modport slave (
        input  start, cfg_k, cfg_row_length, cfg_num_rows, cfg_channels,
        output busy, done, err, shifting_line, shifting_filter, mac_enable,
               nl_enable, feedback_enable, adder_enable, line_buffer_reset,
               row_length
    );
endinterface

// File: rtl/pe_array_sequencer_mask_gen.sv
// Active-PE mask M(r,c)=(r<k && c<k) and column mask C(c)=(c<k) from kernel size.
// Latency: combinational.
// Backpressure: none.

module pe_seq_mask_gen
    import pe_seq_pkg::*;
(
    input  logic [K_W-1:0]       k,
    output logic [N_PE*N_PE-1:0] pe_mask,
    output logic [N_PE-1:0]      col_mask
);

    // Square k x k corner of the array is active; flat bit is r*N_PE+c.
    always_comb begin
        pe_mask  = '0;
        col_mask = '0;
        for (int c = 0; c < N_PE; c++) begin
            col_mask[c] = (c < int'(k));
        end
        for (int r = 0; r < N_PE; r++) begin
            for (int c = 0; c < N_PE; c++) begin
                pe_mask[r*N_PE + c] = (r < int'(k)) && (c < int'(k));
            end
        end
    end

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences line-buffer reset, filter load, fill, compute and drain for a k x k PE array.
// Latency: first control (line_buffer_reset) one cycle after start is accepted; all outputs registered.
// Backpressure: start is edge-detected and honoured only in IDLE; ignored while busy.
// Optional feature macro: PE_SEQ_FEEDBACK_EN (multi-pass accumulation over cfg_channels).

module pe_array_sequencer
    import pe_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pe_array_sequencer_if.slave bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [K_W-1:0]      k_q;
    logic [ADDR_W-1:0]   rl_q;
    logic [ADDR_W-1:0]   nr_q;
    logic                start_q;

    logic [N_PE*N_PE-1:0] pe_mask;
    logic [N_PE-1:0]      col_mask;

    logic [CNT_W-1:0]    load_len, fill_len, comp_len;
    logic                start_rise, accept, reject, more_passes;

    logic                busy_q, done_q, err_q, lb_rst_q;
    logic [N_PE*N_PE-1:0] sl_q, sf_q, mac_q;
    logic [N_PE-1:0]      nl_q, fb_q, add_q;

`ifdef PE_SEQ_FEEDBACK_EN
    logic [CHAN_W-1:0]   chan_q;
    logic [CHAN_W-1:0]   pass_q, pass_d;
    logic [CHAN_W:0]     passes;
`else
    // Channel count has no effect in single-pass builds.
    logic unused_cfg_channels;
    assign unused_cfg_channels = ^bus.cfg_channels;
`endif

    pe_seq_mask_gen u_mask_gen (
        .k        (k_q),
        .pe_mask  (pe_mask),
        .col_mask (col_mask)
    );

    // Phase lengths from the latched command; cfg_legal guarantees k>=1, nr>=k.
    always_comb begin
        load_len = CNT_W'(k_q);
        fill_len = (CNT_W'(k_q) - CNT_W'(1)) * CNT_W'(rl_q);
        comp_len = (CNT_W'(nr_q) - CNT_W'(k_q) + CNT_W'(1)) * CNT_W'(rl_q);
    end

    assign start_rise = bus.start & ~start_q;

`ifdef PE_SEQ_FEEDBACK_EN
    assign passes      = (chan_q == '0) ? (CHAN_W+1)'(1) : {1'b0, chan_q};
    assign more_passes = (({1'b0, pass_q} + (CHAN_W+1)'(1)) < passes);
`else
    assign more_passes = 1'b0;
`endif

    // Next-state and counter logic; counter restarts at 0 on each state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        reject  = 1'b0;
`ifdef PE_SEQ_FEEDBACK_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    if (cfg_legal(bus.cfg_k, bus.cfg_row_length, bus.cfg_num_rows)) begin
                        accept  = 1'b1;
                        state_d = S_LB_RST;
                        cnt_d   = '0;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            S_LB_RST: begin
                state_d = S_LOAD_FILTER;
                cnt_d   = '0;
            end
            S_LOAD_FILTER: begin
                if (cnt_q == load_len - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = (k_q == K_W'(1)) ? S_COMPUTE : S_FILL;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (cnt_q == fill_len - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_COMPUTE: begin
                if (cnt_q == comp_len - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_d = '0;
`ifdef PE_SEQ_FEEDBACK_EN
                if (more_passes) begin
                    state_d = S_LB_RST;
                    pass_d  = pass_q + CHAN_W'(1);
                end else begin
                    state_d = S_IDLE;
                    pass_d  = '0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and latched command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            rl_q    <= '0;
            nr_q    <= '0;
            start_q <= 1'b0;
`ifdef PE_SEQ_FEEDBACK_EN
            chan_q  <= '0;
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= bus.start;
`ifdef PE_SEQ_FEEDBACK_EN
            pass_q  <= pass_d;
`endif
            if (accept) begin
                k_q    <= bus.cfg_k;
                rl_q   <= bus.cfg_row_length;
                nr_q   <= bus.cfg_num_rows;
`ifdef PE_SEQ_FEEDBACK_EN
                chan_q <= bus.cfg_channels;
`endif
            end
        end
    end

    // Outputs decoded from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lb_rst_q <= 1'b0;
            sl_q     <= '0;
            sf_q     <= '0;
            mac_q    <= '0;
            nl_q     <= '0;
            fb_q     <= '0;
            add_q    <= '0;
        end else begin
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE) && !more_passes;
            err_q    <= reject;
            lb_rst_q <= (state_d == S_LB_RST);
            sf_q     <= (state_d == S_LOAD_FILTER) ? pe_mask : '0;
            sl_q     <= (state_d == S_FILL || state_d == S_COMPUTE) ? pe_mask : '0;
            mac_q    <= (state_d == S_COMPUTE) ? pe_mask : '0;
            add_q    <= (state_d == S_DRAIN && cnt_d == '0) ? col_mask : '0;
            nl_q     <= (state_d == S_DRAIN && cnt_d == CNT_W'(1)) ? col_mask : '0;
`ifdef PE_SEQ_FEEDBACK_EN
            fb_q     <= ((state_d == S_COMPUTE || state_d == S_DRAIN) && pass_d != '0)
                        ? col_mask : '0;
`else
            fb_q     <= '0;
`endif
        end
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.line_buffer_reset = lb_rst_q;
    assign bus.shifting_line     = sl_q;
    assign bus.shifting_filter   = sf_q;
    assign bus.mac_enable        = mac_q;
    assign bus.nl_enable         = nl_q;
    assign bus.feedback_enable   = fb_q;
    assign bus.adder_enable      = add_q;
    assign bus.row_length        = rl_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: command table with scoreboard plus corner sequences.
// Latency: n/a.
// Backpressure: n/a.

module tb_pe_array_sequencer;
    import pe_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_array_sequencer_if bus ();

    pe_array_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int k, rl, nr, ch;
        int e_err, e_busy, e_lb, e_load, e_fill, e_comp, e_add, e_nl, e_fb, e_done;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    int checks = 0;
    int errors = 0;

    logic [N_PE*N_PE-1:0] exp_m = '0;
    logic [N_PE-1:0]      exp_c = '0;

    // Monitor counters only ever increase; the stimulus side takes differences.
    int m_busy = 0, m_lb = 0, m_load = 0, m_fill = 0, m_comp = 0;
    int m_add = 0, m_nl = 0, m_fb = 0, m_done = 0, m_err = 0, m_bad = 0;

    function automatic logic [N_PE*N_PE-1:0] mask_of(input int k);
        logic [N_PE*N_PE-1:0] m;
        logic [N_PE-1:0]      row;
        m   = '0;
        row = (k >= N_PE) ? '1 : N_PE'((1 << k) - 1);
        for (int r = 0; r < N_PE; r++)
            if (r < k) m[r*N_PE +: N_PE] = row;
        return m;
    endfunction

    function automatic logic [N_PE-1:0] cmask_of(input int k);
        return (k >= N_PE) ? '1 : N_PE'((1 << k) - 1);
    endfunction

    always @(negedge clk) begin
        if (bus.busy) m_busy <= m_busy + 1;
        if (bus.line_buffer_reset) m_lb <= m_lb + 1;
        if (bus.shifting_filter != '0 && bus.shifting_filter == exp_m) m_load <= m_load + 1;
        if (bus.shifting_line != '0 && bus.shifting_line == exp_m && bus.mac_enable == '0)
            m_fill <= m_fill + 1;
        if (bus.mac_enable != '0 && bus.mac_enable == exp_m && bus.shifting_line == exp_m)
            m_comp <= m_comp + 1;
        if (bus.adder_enable != '0 && bus.adder_enable == exp_c) m_add <= m_add + 1;
        if (bus.nl_enable != '0 && bus.nl_enable == exp_c) m_nl <= m_nl + 1;
        if (bus.feedback_enable != '0 && bus.feedback_enable == exp_c) m_fb <= m_fb + 1;
        if (bus.done) m_done <= m_done + 1;
        if (bus.err) m_err <= m_err + 1;
        if ((bus.shifting_filter != '0 && bus.shifting_filter != exp_m) ||
            (bus.shifting_line   != '0 && bus.shifting_line   != exp_m) ||
            (bus.mac_enable      != '0 && bus.mac_enable      != exp_m) ||
            (bus.adder_enable    != '0 && bus.adder_enable    != exp_c) ||
            (bus.nl_enable       != '0 && bus.nl_enable       != exp_c) ||
            (bus.feedback_enable != '0 && bus.feedback_enable != exp_c) ||
            (!bus.busy && (bus.line_buffer_reset || bus.done || bus.shifting_filter != '0 ||
                           bus.shifting_line != '0 || bus.mac_enable != '0 ||
                           bus.adder_enable != '0 || bus.nl_enable != '0 ||
                           bus.feedback_enable != '0)) ||
            ((int'(bus.line_buffer_reset) + int'(bus.shifting_filter != '0) +
              int'(bus.shifting_line != '0) + int'(bus.adder_enable != '0) +
              int'(bus.nl_enable != '0)) > 1))
            m_bad <= m_bad + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        bus.cfg_k          = K_W'(v.k);
        bus.cfg_row_length = ADDR_W'(v.rl);
        bus.cfg_num_rows   = ADDR_W'(v.nr);
        bus.cfg_channels   = CHAN_W'(v.ch);
        exp_m              = mask_of(v.k);
        exp_c              = cmask_of(v.k);
    endtask

    task automatic run_cmd(input int idx, input vec_t v);
        int b_busy, b_lb, b_load, b_fill, b_comp, b_add, b_nl, b_fb, b_done, b_err, b_bad;
        bit fin;
        vec_t e;
        @(negedge clk); #1;
        b_busy = m_busy; b_lb = m_lb; b_load = m_load; b_fill = m_fill; b_comp = m_comp;
        b_add = m_add; b_nl = m_nl; b_fb = m_fb; b_done = m_done; b_err = m_err; b_bad = m_bad;
        exp_q.push_back(v);
        @(negedge clk);
        drive_cfg(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 8000 && !fin; i++) begin
            @(negedge clk); #1;
            if (m_done > b_done || m_err > b_err) fin = 1'b1;
        end
        chk($sformatf("v%0d completion seen", idx), int'(fin), 1);
        repeat (4) @(negedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d err pulses", idx),   m_err  - b_err,  e.e_err);
        chk($sformatf("v%0d busy cycles", idx),  m_busy - b_busy, e.e_busy);
        chk($sformatf("v%0d lb_reset", idx),     m_lb   - b_lb,   e.e_lb);
        chk($sformatf("v%0d load_filter", idx),  m_load - b_load, e.e_load);
        chk($sformatf("v%0d fill", idx),         m_fill - b_fill, e.e_fill);
        chk($sformatf("v%0d compute", idx),      m_comp - b_comp, e.e_comp);
        chk($sformatf("v%0d adder", idx),        m_add  - b_add,  e.e_add);
        chk($sformatf("v%0d nl", idx),           m_nl   - b_nl,   e.e_nl);
        chk($sformatf("v%0d feedback", idx),     m_fb   - b_fb,   e.e_fb);
        chk($sformatf("v%0d done pulses", idx),  m_done - b_done, e.e_done);
        chk($sformatf("v%0d stray outputs", idx), m_bad - b_bad,  0);
        chk($sformatf("v%0d busy at end", idx),  int'(bus.busy),  0);
        if (e.e_err == 0)
            chk($sformatf("v%0d row_length", idx), int'(bus.row_length), e.rl);
    endtask

    function automatic int any_out();
        return int'(bus.busy || bus.done || bus.err || bus.line_buffer_reset ||
                    bus.shifting_line != '0 || bus.shifting_filter != '0 ||
                    bus.mac_enable != '0 || bus.nl_enable != '0 ||
                    bus.feedback_enable != '0 || bus.adder_enable != '0);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_err, b_busy;
        bit hit;

        //          k  rl  nr ch  err busy lb load fill comp add nl fb done
        vecs[0]  = '{3,  4,  5, 1,  0,  27, 1, 3,   8,  12,  1, 1, 0, 1};
        vecs[1]  = '{1,  2,  2, 1,  0,   9, 1, 1,   0,   4,  1, 1, 0, 1};
        vecs[2]  = '{4,  1,  4, 1,  0,  12, 1, 4,   3,   1,  1, 1, 0, 1};
        vecs[3]  = '{5,  4,  5, 1,  1,   0, 0, 0,   0,   0,  0, 0, 0, 0};
        vecs[4]  = '{3,  4,  2, 1,  1,   0, 0, 0,   0,   0,  0, 0, 0, 0};
        vecs[5]  = '{0,  4,  5, 1,  1,   0, 0, 0,   0,   0,  0, 0, 0, 0};
        vecs[6]  = '{2,  0,  5, 1,  1,   0, 0, 0,   0,   0,  0, 0, 0, 0};
`ifdef PE_SEQ_FEEDBACK_EN
        vecs[7]  = '{2,  3,  3, 2,  0,  30, 2, 4,   6,  12,  2, 2, 8, 1};
`else
        vecs[7]  = '{2,  3,  3, 2,  0,  15, 1, 2,   3,   6,  1, 1, 0, 1};
`endif
        vecs[8]  = '{2,  3,  3, 0,  0,  15, 1, 2,   3,   6,  1, 1, 0, 1};
        vecs[9]  = '{2, 100, 50, 1, 0, 5006, 1, 2, 100, 4900, 1, 1, 0, 1};
        vecs[10] = '{4,  4,  4, 1,  0,  24, 1, 4,  12,   4,  1, 1, 0, 1};

        rst = 1'b1;
        bus.start = 1'b0;
        drive_cfg(vecs[0]);
        repeat (3) @(negedge clk);
        chk("reset outputs", any_out(), 0);
        chk("reset row_length", int'(bus.row_length), 0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_cmd(i, vecs[i]);

        // Reset in the middle of COMPUTE
        @(negedge clk); #1;
        b_done = m_done;
        drive_cfg(vecs[0]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.mac_enable != '0) hit = 1'b1;
        end
        chk("midrun reached compute", int'(hit), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun reset outputs", any_out(), 0);
        chk("midrun reset row_length", int'(bus.row_length), 0);
        repeat (30) @(negedge clk);
        #1;
        chk("midrun no done", m_done - b_done, 0);
        run_cmd(100, vecs[0]);

        // Reset and start in the same cycle: reset wins
        @(negedge clk); #1;
        b_busy = m_busy; b_err = m_err;
        drive_cfg(vecs[1]);
        bus.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        chk("rst+start busy", int'(bus.busy), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("rst+start busy cycles", m_busy - b_busy, 0);
        chk("rst+start err", m_err - b_err, 0);

        // Start held high across a whole command
        @(negedge clk); #1;
        b_busy = m_busy; b_err = m_err; b_done = m_done;
        drive_cfg(vecs[1]);
        bus.start = 1'b1;
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("held start done", m_done - b_done, 1);
        chk("held start err", m_err - b_err, 0);
        chk("held start busy cycles", m_busy - b_busy, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
